// File: rtl/alluvial_driver.sv
// Command driver for an external combinational ALU: latches operands, waits a
// settle window, then queues {result, carry-error} into a response FIFO.
module alluvial_driver #(
  parameter int SETTLE    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [31:0] alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic        alu_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_error,
  output logic [7:0]  err_count,
  input  logic        clr_err,
  output logic        busy
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W + 1)'(RSP_DEPTH);
  localparam logic [3:0]     SETTLE_C = 4'(SETTLE);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        settle_q, settle_d;
  logic [31:0]       alu_op_q, alu_op_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;
  logic [8:0]        mem_q [RSP_DEPTH];
  logic [8:0]        mem_d [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [7:0]        err_q, err_d;
  logic              ready_en_q, ready_en_d;

  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic push;
  logic pop;
  logic push_err;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q;
    ready_en_d = 1'b1;
    push       = 1'b0;

    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    // ready_en_q holds cmd_ready low until the first edge after reset release
    cmd_ready  = ready_en_q && (state_q == IDLE) && !fifo_full;
    accept     = cmd_valid && cmd_ready;
    pop        = !fifo_empty && rsp_ready;
    push_err   = (alu_op_q == 32'd0) && alu_error;

    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_op_d = cmd_op;
          alu_a_d  = cmd_a;
          alu_b_d  = cmd_b;
          settle_d = SETTLE_C;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {alu_result, push_err};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear has priority, so a carry landing on the clear edge is dropped
    if (clr_err) begin
      err_d = 8'd0;
    end else if (push && push_err && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      settle_q   <= 4'd0;
      alu_op_q   <= 32'd0;
      alu_a_q    <= 8'd0;
      alu_b_q    <= 8'd0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 8'd0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = (count_q != '0);
  assign rsp_result = (count_q != '0) ? mem_q[rd_ptr_q][8:1] : 8'd0;
  assign rsp_error  = (count_q != '0) ? mem_q[rd_ptr_q][0] : 1'b0;
  assign err_count  = err_q;
  assign busy       = (state_q == DRIVE);

endmodule

// File: tb/tb_alluvial_driver.sv
// Directed testbench for alluvial_driver with a behavioural ALU model
// (ADD / XOR / NAND, carry on alu_error, optional forced error for non-ADD ops).
module tb_alluvial_driver;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [31:0] alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        alu_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_error;
  logic [7:0]  err_count;
  logic        clr_err;
  logic        busy;

  logic        force_err;
  logic [8:0]  add_sum;
  int          errors;
  int          checks;

  alluvial_driver #(.SETTLE(1), .RSP_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .err_count  (err_count),
    .clr_err    (clr_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: error is the ADD carry, or force_err for other ops
  assign add_sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = (alu_op == 32'd0) ? add_sum[7:0] :
                      (alu_op == 32'd1) ? (alu_a ^ alu_b) : ~(alu_a & alu_b);
  assign alu_error  = (alu_op == 32'd0) ? add_sum[8] : force_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [31:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("[TB] FAIL issue_timeout: cmd_ready=%0b required 1 within 50 cycles", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_flags: ready/valid/busy=%b required 000", {cmd_ready, rsp_valid, busy});
    end
    checks++;
    if ({alu_op, alu_a, alu_b, rsp_result, rsp_error, err_count} !== 65'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs: alu_op=%h a=%h b=%h res=%h err=%b cnt=%h required all 0",
               alu_op, alu_a, alu_b, rsp_result, rsp_error, err_count);
    end
    step();
    step();
    rst_n = 1'b1;
    #2;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: cmd_ready=%b required 0", cmd_ready);
    end
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_add();
    issue_cmd(32'd0, 8'hF0, 8'h20);
    checks++;
    if ({busy, alu_a, alu_b} !== {1'b1, 8'hF0, 8'h20} || alu_op !== 32'd0) begin
      errors++;
      $display("[TB] FAIL add_drive: busy=%b a=%h b=%h op=%0d required 1 f0 20 0", busy, alu_a, alu_b, alu_op);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_result, rsp_error, busy} !== {1'b1, 8'h10, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_rsp: valid=%b res=%h err=%b busy=%b required 1 10 1 0",
               rsp_valid, rsp_result, rsp_error, busy);
    end
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL add_errcnt: err_count=%0d required 1", err_count);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_result, rsp_error} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL add_pop_empty: valid=%b res=%h err=%b required 0 00 0", rsp_valid, rsp_result, rsp_error);
    end
  endtask

  task automatic test_xor();
    force_err = 1'b1;
    issue_cmd(32'd1, 8'hAA, 8'hFF);
    step();
    checks++;
    if ({rsp_valid, rsp_result, rsp_error} !== {1'b1, 8'h55, 1'b0}) begin
      errors++;
      $display("[TB] FAIL xor_rsp: valid=%b res=%h err=%b required 1 55 0", rsp_valid, rsp_result, rsp_error);
    end
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL xor_errcnt: err_count=%0d required 1", err_count);
    end
    force_err = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_nand();
    issue_cmd(32'd7, 8'h0F, 8'h3C);
    checks++;
    if (alu_op !== 32'd7) begin
      errors++;
      $display("[TB] FAIL nand_op: alu_op=%0d required 7", alu_op);
    end
    step();
    checks++;
    if ({rsp_valid, rsp_result, rsp_error} !== {1'b1, 8'hF3, 1'b0}) begin
      errors++;
      $display("[TB] FAIL nand_rsp: valid=%b res=%h err=%b required 1 f3 0", rsp_valid, rsp_result, rsp_error);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_res;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_cmd(32'd0, 8'(i + 1), 8'h10);
    end
    step();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_result} !== {1'b0, 1'b1, 8'h11}) begin
      errors++;
      $display("[TB] FAIL full_state: ready=%b valid=%b head=%h required 0 1 11", cmd_ready, rsp_valid, rsp_result);
    end
    for (int i = 0; i < 4; i++) begin
      exp_res = 8'h11 + 8'(i);
      checks++;
      if ({rsp_valid, rsp_result, rsp_error} !== {1'b1, exp_res, 1'b0}) begin
        errors++;
        $display("[TB] FAIL full_order%0d: valid=%b res=%h err=%b required 1 %h 0",
                 i, rsp_valid, rsp_result, rsp_error, exp_res);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      if (i == 0) begin
        checks++;
        if (cmd_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL full_ready_back: cmd_ready=%b required 1", cmd_ready);
        end
      end
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_drained: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    issue_cmd(32'd1, 8'h01, 8'h02);
    issue_cmd(32'd1, 8'h04, 8'h08);
    rsp_ready = 1'b1;
    step();
    checks++;
    if ({rsp_valid, rsp_result} !== {1'b1, 8'h0C}) begin
      errors++;
      $display("[TB] FAIL b2b_head: valid=%b res=%h required 1 0c", rsp_valid, rsp_result);
    end
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_count: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_err_saturate();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sat_preclear: err_count=%0d required 0", err_count);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue_cmd(32'd0, 8'hF0, 8'h20);
    end
    step();
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_255: err_count=%0d required 255", err_count);
    end
    issue_cmd(32'd0, 8'hF0, 8'h20);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sat_clear_wins: err_count=%0d required 0", err_count);
    end
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    int seen;
    rsp_ready = 1'b0;
    issue_cmd(32'd0, 8'hF0, 8'h20);
    issue_cmd(32'd0, 8'hF0, 8'h20);
    step();
    checks++;
    if ({rsp_valid, err_count} !== {1'b1, 8'd2}) begin
      errors++;
      $display("[TB] FAIL mid_setup: valid=%b err_count=%0d required 1 2", rsp_valid, err_count);
    end
    issue_cmd(32'd0, 8'hF0, 8'h20);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, err_count, busy, cmd_ready, alu_a} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b cnt=%0d busy=%b ready=%b alu_a=%h required all 0",
               rsp_valid, err_count, busy, cmd_ready, alu_a);
    end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL mid_no_rsp: valid cycles=%0d required 0", seen);
    end
    issue_cmd(32'd1, 8'h3C, 8'h0F);
    step();
    checks++;
    if ({rsp_valid, rsp_result} !== {1'b1, 8'h33}) begin
      errors++;
      $display("[TB] FAIL mid_recover: valid=%b res=%h required 1 33", rsp_valid, rsp_result);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 32'd0;
    cmd_a     = 8'd0;
    cmd_b     = 8'd0;
    rsp_ready = 1'b0;
    clr_err   = 1'b0;
    force_err = 1'b0;
    $display("[TB] starting alluvial_driver tests");
    test_reset();
    test_add();
    test_xor();
    test_nand();
    test_fifo_full();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid_drive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
